// File: rtl/cmat_row_server_pkg.sv
// Shared types and constants for the complex-matrix row server (package cmat_pkg).
package cmat_pkg;

  localparam int unsigned CPLX_W = 128;

  typedef struct packed {
    logic [63:0] im;
    logic [63:0] re;
  } complex_t;

  localparam complex_t CPLX_ONE = 128'h0000000000000000_3ff0000000000000;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT_BUSY,
    SERVE
  } cmat_row_state_t;

  function automatic int unsigned addr_w(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/cmat_row_server_if.sv
// Row write and row-read bus between the matrix source, the row server and the inverter.
interface cmat_row_server_if
  import cmat_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  localparam int unsigned AW   = addr_w(SIZE)
);

  logic [SIZE*CPLX_W-1:0] wr_row_i;
  logic [AW-1:0]          wr_addr_i;
  logic                   wr_valid_i;
  logic                   wr_ready_o;
  logic [AW-1:0]          rd_addr_i;
  logic                   rd_valid_i;
  logic [SIZE*CPLX_W-1:0] row_o;
  logic [AW-1:0]          row_addr_o;
  logic                   row_valid_o;

  modport master (
    output wr_row_i, wr_addr_i, wr_valid_i, rd_addr_i, rd_valid_i,
    input  wr_ready_o, row_o, row_addr_o, row_valid_o
  );

  modport slave (
    input  wr_row_i, wr_addr_i, wr_valid_i, rd_addr_i, rd_valid_i,
    output wr_ready_o, row_o, row_addr_o, row_valid_o
  );

endinterface

// File: rtl/cmat_row_mem.sv
// Row storage: one write port, one registered read port; contents are not reset.
module cmat_row_mem
  import cmat_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 16 * CPLX_W,
  localparam int unsigned AW    = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // Read register holds its last value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_rdata <= '0;
    else if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/cmat_row_server.sv
// Loads a SIZE x SIZE complex matrix row by row, starts the inverter, then serves its row reads.
// Optional: CMAT_ROW_ZERO_UPPER_EN forces elements above the diagonal of served rows to zero.
module cmat_row_server
  import cmat_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  localparam int unsigned AW   = addr_w(SIZE),
  localparam int unsigned RW   = SIZE * CPLX_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cmat_row_server_if.slave    bus,
  output logic                start_o,
  input  logic                consumer_busy_i,
  input  logic                flush_i,
  output logic                full_o,
  output logic                busy_o
);

  cmat_row_state_t r_state;
  logic [SIZE-1:0] r_present;
  logic [SIZE-1:0] w_present_nxt;
  logic            r_wr_ready;
  logic            r_start;
  logic            r_full;
  logic            r_busy;
  logic            r_row_valid;
  logic [AW-1:0]   r_row_addr;

  logic            w_wr_in_range;
  logic            w_rd_in_range;
  logic            w_wr_fire;
  logic            w_wr_store;
  logic            w_rd_fire;
  logic [RW-1:0]   w_mem_row;
  logic [RW-1:0]   w_row_out;
  complex_t        w_el;

  always_comb begin
    w_wr_in_range = 32'(bus.wr_addr_i) < SIZE;
    w_rd_in_range = 32'(bus.rd_addr_i) < SIZE;
    w_wr_fire     = r_wr_ready && bus.wr_valid_i && !flush_i;
    w_wr_store    = w_wr_fire && w_wr_in_range;
    w_rd_fire     = (r_state != LOAD) && bus.rd_valid_i && w_rd_in_range && !flush_i;
    w_present_nxt = r_present;
    if (w_wr_store) w_present_nxt[bus.wr_addr_i] = 1'b1;
  end

  cmat_row_mem #(
    .DEPTH (SIZE),
    .WIDTH (RW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_wr_store),
    .waddr_i (bus.wr_addr_i),
    .wdata_i (bus.wr_row_i),
    .re_i    (w_rd_fire),
    .raddr_i (bus.rd_addr_i),
    .rdata_o (w_mem_row)
  );

  // Outputs are registered alongside the state so they change in the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= LOAD;
      r_present   <= '0;
      r_wr_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_addr  <= '0;
    end else begin
      r_start     <= 1'b0;
      r_row_valid <= w_rd_fire;
      if (w_rd_fire) r_row_addr <= bus.rd_addr_i;
      if (flush_i) begin
        r_state    <= LOAD;
        r_present  <= '0;
        r_wr_ready <= 1'b1;
        r_full     <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        unique case (r_state)
          LOAD: begin
            r_present <= w_present_nxt;
            if (&w_present_nxt) begin
              r_state    <= START;
              r_start    <= 1'b1;
              r_wr_ready <= 1'b0;
              r_full     <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          START: r_state <= WAIT_BUSY;
          WAIT_BUSY: begin
            if (consumer_busy_i) r_state <= SERVE;
          end
          SERVE: begin
            if (!consumer_busy_i) begin
              r_state    <= LOAD;
              r_present  <= '0;
              r_wr_ready <= 1'b1;
              r_full     <= 1'b0;
              r_busy     <= 1'b0;
            end
          end
          default: r_state <= LOAD;
        endcase
      end
    end
  end

  // Masking keys off the registered row address, so held rows stay consistent.
  always_comb begin
    w_row_out = '0;
    w_el      = '0;
    for (int unsigned j = 0; j < SIZE; j++) begin
      w_el = w_mem_row[j*CPLX_W +: CPLX_W];
`ifdef CMAT_ROW_ZERO_UPPER_EN
      if (j > 32'(r_row_addr)) w_el = '0;
`endif
      w_row_out[j*CPLX_W +: CPLX_W] = w_el;
    end
  end

  assign bus.wr_ready_o  = r_wr_ready;
  assign bus.row_o       = w_row_out;
  assign bus.row_addr_o  = r_row_addr;
  assign bus.row_valid_o = r_row_valid;
  assign start_o         = r_start;
  assign full_o          = r_full;
  assign busy_o          = r_busy;

endmodule
